uart_bus_master: RTL and testbench

//  Bus initiator driven from the UART receive path: parses host command frames (rx bytes), issues
//  we/addr/wd write or addr/data read cycles on the CPU-side I/O bus, returns reply bytes via UART tx.

---
 rtl/uart_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_uart_bus_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// Purpose: UART command-frame parser that drives word read/write cycles on the CPU I/O bus and returns reply bytes.
// Latency: bus cycle starts 1 clk after the last frame byte (2-cycle BUS phase); the first reply byte loads 1 clk after that if the tx is idle.
// Backpressure: reply bytes stall on tx_busy; rx bytes arriving during BUS/SEND/TXWAIT are dropped and set sticky overrun.
// Optional: define BRIDGE_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module uart_bus_master #(
    parameter int unsigned TX_GUARD       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic        tx_we,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    output logic [1:0]  we,
    output logic [31:0] addr,
    output logic [31:0] wd,
    input  logic [31:0] rd,
    output logic        overrun
);

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        BUS    = 3'd3,
        SEND   = 3'd4,
        TXWAIT = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        is_write;
    logic        bus_phase;
    logic [31:0] reply_sr;
    logic [2:0]  reply_left;
    logic [7:0]  guard;
    logic        timeout_hit;
    logic        in_frame;

    assign in_frame = (state == ADDR) || (state == DATA);

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Idle-cycle counter inside a partial frame; reloads on every received byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= 32'd0;
        end else if (rx_valid || !in_frame) begin
            to_cnt <= 32'd0;
        end else begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timeout_hit = in_frame && !rx_valid && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: a partial frame waits forever; the parameter has no effect.
    assign timeout_hit = in_frame && 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

    // Frame parser, bus sequencer and reply transmitter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            is_write   <= 1'b0;
            bus_phase  <= 1'b0;
            reply_sr   <= 32'd0;
            reply_left <= 3'd0;
            guard      <= 8'd0;
            tx_we      <= 1'b0;
            tx_data    <= 8'd0;
            bus_req    <= 1'b0;
            we         <= 2'b00;
            addr       <= 32'd0;
            wd         <= 32'd0;
            overrun    <= 1'b0;
        end else begin
            tx_we <= 1'b0;
            if (rx_valid && (state == BUS || state == SEND || state == TXWAIT)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cnt <= 2'd0;
                        if (rx_data == CMD_W) begin
                            is_write <= 1'b1;
                            state    <= ADDR;
                        end else if (rx_data == CMD_R) begin
                            is_write <= 1'b0;
                            state    <= ADDR;
                        end else begin
                            reply_sr   <= {24'd0, RSP_BAD};
                            reply_left <= 3'd1;
                            state      <= SEND;
                        end
                    end
                end
                ADDR: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        // LSB-first bytes shifted in from the top land in order after four bytes.
                        addr <= {rx_data, addr[31:8]};
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                state     <= BUS;
                                bus_req   <= 1'b1;
                                we        <= 2'b00;
                                bus_phase <= 1'b0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        wd  <= {rx_data, wd[31:8]};
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state     <= BUS;
                            bus_req   <= 1'b1;
                            we        <= 2'b11;
                            bus_phase <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    if (!bus_phase) begin
                        bus_phase <= 1'b1;
                        we        <= 2'b00;
                    end else begin
                        // End of second bus cycle: rd is still driven from the held addr.
                        bus_req <= 1'b0;
                        we      <= 2'b00;
                        state   <= SEND;
                        if (is_write) begin
                            reply_sr   <= {24'd0, RSP_OK};
                            reply_left <= 3'd1;
                        end else begin
                            reply_sr   <= rd;
                            reply_left <= 3'd4;
                        end
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_we      <= 1'b1;
                        tx_data    <= reply_sr[7:0];
                        reply_sr   <= {8'd0, reply_sr[31:8]};
                        reply_left <= reply_left - 3'd1;
                        guard      <= 8'(TX_GUARD);
                        state      <= TXWAIT;
                    end
                end
                TXWAIT: begin
                    // tx_busy lags the load pulse, so ignore it for TX_GUARD cycles.
                    if (guard != 8'd0) begin
                        guard <= guard - 8'd1;
                    end else if (!tx_busy) begin
                        state <= (reply_left == 3'd0) ? IDLE : SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        tx_busy;
    logic        tx_we;
    logic [7:0]  tx_data;
    logic        bus_req;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        overrun;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0]  txq[$];
    int          busy_cnt = 0;
    logic        force_busy = 1'b0;
    logic        prev_tx_we = 1'b0;
    int          txwe_wide = 0;
    int          busreq_cyc = 0;
    int          wr_cnt = 0;
    int          we_bad = 0;
    logic [31:0] waddr = 32'd0;
    logic [31:0] wdat = 32'd0;

    uart_bus_master #(.TX_GUARD(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_we(tx_we), .tx_data(tx_data), .bus_req(bus_req),
        .we(we), .addr(addr), .wd(wd), .rd(rd), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bus slave: one preloaded word, everything else reads back inverted address.
    assign rd = (addr == 32'hFFF0_0000) ? 32'h1234_5678 : ~addr;
    assign tx_busy = force_busy || (busy_cnt != 0);

    // Monitor on the falling edge: uart model plus bus/tx protocol observations.
    always @(negedge clk) begin
        if (tx_we) begin
            txq.push_back(tx_data);
            busy_cnt = 6;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
        end
        if (tx_we && prev_tx_we) txwe_wide = txwe_wide + 1;
        prev_tx_we = tx_we;
        if (bus_req) busreq_cyc = busreq_cyc + 1;
        if (bus_req && we == 2'b11) begin
            wr_cnt = wr_cnt + 1;
            waddr  = addr;
            wdat   = wd;
        end
        if (!bus_req && we != 2'b00) we_bad = we_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp = ncmp + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        txq.delete();
        busreq_cyc = 0;
        wr_cnt     = 0;
        waddr      = 32'd0;
        wdat       = 32'd0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int budget;
        budget = 2000;
        while (txq.size() < n && budget > 0) begin
            @(negedge clk);
            budget = budget - 1;
        end
        repeat (20) @(negedge clk);
        check(tag, 32'(txq.size()), 32'(n));
    endtask

    function automatic logic [7:0] qget(input int i);
        return (txq.size() > i) ? txq[i] : 8'h00;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_we",   {31'd0, tx_we}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_we",      {30'd0, we}, 32'd0);
        check("rst_addr",    addr, 32'd0);
        check("rst_wd",      wd, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word write.
        clear_obs();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_tx("wr_reply_cnt", 1);
        check("wr_reply",   {24'd0, qget(0)}, 32'h4B);
        check("wr_cycles",  32'(wr_cnt), 32'd1);
        check("wr_addr",    waddr, 32'h0000_0010);
        check("wr_data",    wdat, 32'hDEAD_BEEF);
        check("wr_busreq",  32'(busreq_cyc), 32'd2);

        // Word read.
        clear_obs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF0); send_byte(8'hFF);
        wait_tx("rd_reply_cnt", 4);
        check("rd_b0", {24'd0, qget(0)}, 32'h78);
        check("rd_b1", {24'd0, qget(1)}, 32'h56);
        check("rd_b2", {24'd0, qget(2)}, 32'h34);
        check("rd_b3", {24'd0, qget(3)}, 32'h12);
        check("rd_no_write", 32'(wr_cnt), 32'd0);
        check("rd_busreq",   32'(busreq_cyc), 32'd2);

        // Unknown command, then a fresh read frame.
        clear_obs();
        send_byte(8'h41);
        wait_tx("bad_reply_cnt", 1);
        check("bad_reply",  {24'd0, qget(0)}, 32'h3F);
        check("bad_busreq", 32'(busreq_cyc), 32'd0);
        clear_obs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF0); send_byte(8'hFF);
        wait_tx("after_bad_cnt", 4);
        check("after_bad_b0", {24'd0, qget(0)}, 32'h78);
        check("after_bad_b3", {24'd0, qget(3)}, 32'h12);

        // Overrun during a stalled reply, with tx_busy held high for 50 cycles.
        clear_obs();
        check("ovr_before", {31'd0, overrun}, 32'd0);
        force_busy = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF0); send_byte(8'hFF);
        repeat (5) @(negedge clk);
        send_byte(8'h99);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        repeat (50) @(negedge clk);
        check("busy_no_tx", 32'(txq.size()), 32'd0);
        force_busy = 1'b0;
        wait_tx("ovr_reply_cnt", 4);
        check("ovr_b0", {24'd0, qget(0)}, 32'h78);
        check("ovr_b1", {24'd0, qget(1)}, 32'h56);
        check("ovr_b2", {24'd0, qget(2)}, 32'h34);
        check("ovr_b3", {24'd0, qget(3)}, 32'h12);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

`ifdef BRIDGE_TIMEOUT_EN
        // Partial frame abandoned after 100 idle cycles.
        clear_obs();
        send_byte(8'h57); send_byte(8'h10);
        repeat (120) @(negedge clk);
        check("to_no_tx", 32'(txq.size()), 32'd0);
        send_byte(8'h41);
        wait_tx("to_idle_cnt", 1);
        check("to_idle_reply", {24'd0, qget(0)}, 32'h3F);
        check("to_no_write", 32'(wr_cnt), 32'd0);
`else
        // Partial frame waits indefinitely, then completes.
        clear_obs();
        send_byte(8'h57); send_byte(8'h10);
        repeat (200) @(negedge clk);
        check("nto_no_tx", 32'(txq.size()), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        wait_tx("nto_reply_cnt", 1);
        check("nto_reply", {24'd0, qget(0)}, 32'h4B);
        check("nto_addr",  waddr, 32'h0000_0010);
        check("nto_data",  wdat, 32'h1122_3344);
`endif

        // Reset in the middle of a read frame.
        send_byte(8'h52); send_byte(8'hAA); send_byte(8'hBB);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_addr",    addr, 32'd0);
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh write after reset parses from a clean state.
        clear_obs();
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        wait_tx("post_rst_cnt", 1);
        check("post_rst_addr", waddr, 32'h0000_0020);
        check("post_rst_data", wdat, 32'h0102_0304);

        check("tx_we_width", 32'(txwe_wide), 32'd0);
        check("we_idle",     32'(we_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
